// File: rtl/dzcpu_useq.sv
// dzcpu_useq: microcode sequencer. Latches opcodes, walks the micro-op ROM address and decodes flow strobes.
// Interrupt entry at instruction boundaries is compiled in with `define DZCPU_INT_DISPATCH_EN.
module dzcpu_useq #(
  parameter int unsigned ADDR_W       = 8,
  parameter logic [7:0]  INT_FLOW_IDX = 8'd169
) (
  input  logic              iClock,
  input  logic              iReset_n,
  input  logic              iStall,
  input  logic [7:0]        iMop,
  input  logic [ADDR_W-1:0] iLutIdx,
  input  logic [ADDR_W-1:0] iCbLutIdx,
  input  logic              iFlowInc,
  input  logic              iFlowEof,
  input  logic              iFlowEofZ,
  input  logic              iFlowEofNz,
  input  logic              iFlowJcb,
  input  logic              iFlowFu,
  input  logic              iZero,
  input  logic              iSeti,
  input  logic              iCeti,
  input  logic [4:0]        iIntFlags,
  input  logic [4:0]        iIntEnable,
  output logic [ADDR_W-1:0] oUopAddr,
  output logic [7:0]        oMop,
  output logic              oPcInc,
  output logic              oFlagUpdate,
  output logic [2:0]        oState,
  output logic              oFault,
  output logic [4:0]        oIntAck,
  output logic [7:0]        oIntVector
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_CBDEC  = 3'd3,
    S_INT    = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [ADDR_W-1:0] INT_ADDR = ADDR_W'(INT_FLOW_IDX);

  state_t            state_reg;
  logic [ADDR_W-1:0] uop_addr_reg;
  logic [7:0]        mop_reg;
  logic              fault_reg;
  logic              cb_flow_reg;   // a CB-page flow is running; further JCBs just step

  logic flow_end;
  logic exec_live;
  logic at_top;
  logic int_req;

  assign flow_end  = iFlowEof | (iFlowEofZ & iZero) | (iFlowEofNz & ~iZero);
  assign exec_live = (state_reg == S_EXEC) & ~iStall;
  assign at_top    = &uop_addr_reg;

`ifdef DZCPU_INT_DISPATCH_EN
  logic       ime_reg;
  logic [7:0] int_vector_reg;
  logic [4:0] int_pending;
  logic [4:0] int_lowest;
  logic [2:0] int_n;

  assign int_pending = iIntFlags & iIntEnable;
  assign int_lowest  = int_pending & (~int_pending + 5'd1);
  assign int_req     = ime_reg & (|int_pending);

  always_comb begin
    int_n = 3'd0;
    for (int i = 4; i >= 0; i--) begin
      if (int_pending[i]) int_n = 3'(i);
    end
  end

  assign oIntAck    = (state_reg == S_INT && !iStall) ? int_lowest : 5'd0;
  assign oIntVector = int_vector_reg;

  always_ff @(posedge iClock or negedge iReset_n) begin
    if (!iReset_n) begin
      ime_reg        <= 1'b0;
      int_vector_reg <= 8'h00;
    end else if (!iStall) begin
      if (state_reg == S_INT) begin
        ime_reg        <= 1'b0;
        int_vector_reg <= 8'h40 + {2'b00, int_n, 3'b000};
      end else if (state_reg == S_EXEC) begin
        if (iCeti)      ime_reg <= 1'b0;
        else if (iSeti) ime_reg <= 1'b1;
      end
    end
  end
`else
  logic unused_int;
  assign unused_int = ^{iSeti, iCeti, iIntFlags, iIntEnable, INT_ADDR};
  assign int_req    = 1'b0;
  assign oIntAck    = 5'd0;
  assign oIntVector = 8'h00;
`endif

  always_ff @(posedge iClock or negedge iReset_n) begin
    if (!iReset_n) begin
      state_reg    <= S_FETCH;
      uop_addr_reg <= '0;
      mop_reg      <= 8'h00;
      fault_reg    <= 1'b0;
      cb_flow_reg  <= 1'b0;
    end else if (!iStall) begin
      case (state_reg)
        // The byte at PC is valid during FETCH; latching it here lets the LUT settle during DECODE.
        S_FETCH: begin
          mop_reg   <= iMop;
          state_reg <= S_DECODE;
        end
        S_DECODE: begin
          uop_addr_reg <= iLutIdx;
          cb_flow_reg  <= 1'b0;
          state_reg    <= S_EXEC;
        end
        S_EXEC: begin
          if (flow_end) begin
            state_reg <= int_req ? S_INT : S_FETCH;
          end else if (iFlowJcb && !cb_flow_reg) begin
            mop_reg   <= iMop;
            state_reg <= S_CBDEC;
          end else if (at_top) begin
            fault_reg <= 1'b1;
            state_reg <= S_HALT;
          end else begin
            uop_addr_reg <= uop_addr_reg + ADDR_W'(1);
          end
        end
        S_CBDEC: begin
          uop_addr_reg <= iCbLutIdx;
          cb_flow_reg  <= 1'b1;
          state_reg    <= S_EXEC;
        end
`ifdef DZCPU_INT_DISPATCH_EN
        S_INT: begin
          uop_addr_reg <= INT_ADDR;
          cb_flow_reg  <= 1'b0;
          state_reg    <= S_EXEC;
        end
`endif
        S_HALT: state_reg <= S_HALT;
        default: state_reg <= S_FETCH;
      endcase
    end
  end

  assign oUopAddr    = uop_addr_reg;
  assign oMop        = mop_reg;
  assign oState      = state_reg;
  assign oFault      = fault_reg;
  assign oPcInc      = exec_live & iFlowInc;
  assign oFlagUpdate = exec_live & iFlowFu;

endmodule

// File: tb/tb_dzcpu_useq.sv
// Bench for dzcpu_useq: directed flow table, multi-cycle corner sequences, and randomized
// ROM/program runs checked against a flow-level trace model.
module tb_dzcpu_useq;

  logic       clk;
  logic       rst_n;
  logic       stall;
  logic [7:0] mop_in;
  logic [7:0] lut_idx;
  logic [7:0] cb_lut_idx;
  logic       flow_inc, flow_eof, flow_eofz, flow_eofnz, flow_jcb, flow_fu;
  logic       zero;
  logic       seti, ceti;
  logic [4:0] int_flags, int_enable;
  logic [7:0] uop_addr;
  logic [7:0] mop_out;
  logic       pc_inc, flag_update;
  logic [2:0] state_out;
  logic       fault;
  logic [4:0] int_ack;
  logic [7:0] int_vector;

  dzcpu_useq #(.ADDR_W(8), .INT_FLOW_IDX(8'd169)) dut (
    .iClock(clk), .iReset_n(rst_n), .iStall(stall), .iMop(mop_in),
    .iLutIdx(lut_idx), .iCbLutIdx(cb_lut_idx),
    .iFlowInc(flow_inc), .iFlowEof(flow_eof), .iFlowEofZ(flow_eofz),
    .iFlowEofNz(flow_eofnz), .iFlowJcb(flow_jcb), .iFlowFu(flow_fu),
    .iZero(zero), .iSeti(seti), .iCeti(ceti),
    .iIntFlags(int_flags), .iIntEnable(int_enable),
    .oUopAddr(uop_addr), .oMop(mop_out), .oPcInc(pc_inc), .oFlagUpdate(flag_update),
    .oState(state_out), .oFault(fault), .oIntAck(int_ack), .oIntVector(int_vector)
  );

  // ROM word bits: {fu, jcb, eofnz, eofz, eof, inc}
  localparam logic [5:0] R_INC = 6'd1, R_EOF = 6'd2, R_EOFZ = 6'd4,
                         R_EOFNZ = 6'd8, R_JCB = 6'd16, R_FU = 6'd32;

  logic [5:0] rom   [256];
  logic [7:0] lut   [256];
  logic [7:0] cblut [256];
  logic [7:0] prog  [64];
  logic [7:0] pc;

  // Environment: combinational ROM/LUTs and a program memory addressed by a PC the DUT increments.
  assign {flow_fu, flow_jcb, flow_eofnz, flow_eofz, flow_eof, flow_inc} = rom[uop_addr];
  assign lut_idx    = lut[mop_out];
  assign cb_lut_idx = cblut[mop_out];
  assign mop_in     = prog[pc[5:0]];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)      pc <= 8'd0;
    else if (pc_inc) pc <= pc + 8'd1;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", nm, got, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic clear_env();
    for (int i = 0; i < 256; i++) begin
      rom[i] = 6'd0; lut[i] = 8'd0; cblut[i] = 8'd0;
    end
    for (int i = 0; i < 64; i++) prog[i] = 8'd0;
  endtask

  // Waits (bounded) for EXEC at a given address; returns 1 if reached.
  task automatic wait_exec(input logic [7:0] a, output logic ok);
    ok = 1'b0;
    for (int c = 0; c < 30; c++) begin
      if (state_out == 3'd2 && uop_addr == a) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  // ---------------- directed flow table ----------------
  typedef struct {
    logic [7:0] op;
    logic [7:0] idx;
    logic       z;
    logic [7:0] first_addr;
    logic [7:0] last_addr;
    int         exec_n;
    int         inc_n;
    int         fu_n;
    int         cb_n;
    logic [7:0] last_mop;
  } vec_t;

  vec_t vecs[6];

  // ---------------- trace model ----------------
  typedef struct packed {
    logic [2:0] st;
    logic [7:0] addr;
    logic [7:0] mop;
    logic       flt;
    logic       inc;
    logic       fu;
    logic       z;
  } item_t;

  item_t q[$];

  function automatic item_t mk(input logic [2:0] st, input logic [7:0] a, input logic [7:0] m,
                               input logic f, input logic i, input logic u, input logic z);
    item_t it;
    it.st = st; it.addr = a; it.mop = m; it.flt = f; it.inc = i; it.fu = u; it.z = z;
    return it;
  endfunction

  // Walks whole instructions: FETCH, DECODE, then the flow from the LUT index until its end.
  task automatic build_trace();
    int         mpc;
    logic [7:0] maddr, mmop, op, jop;
    logic [5:0] r;
    logic       cb, f, z, e;
    q.delete();
    mpc = 0; maddr = 8'd0; mmop = 8'd0; f = 1'b0;
    while (!f && q.size() < 300) begin
      q.push_back(mk(3'd0, maddr, mmop, 1'b0, 1'b0, 1'b0, 1'($urandom % 2)));
      op = prog[mpc % 64];
      mmop = op;
      q.push_back(mk(3'd1, maddr, mmop, 1'b0, 1'b0, 1'b0, 1'($urandom % 2)));
      maddr = lut[op];
      cb = 1'b0;
      while (q.size() < 300) begin
        r = rom[maddr];
        z = 1'($urandom % 2);
        q.push_back(mk(3'd2, maddr, mmop, 1'b0, r[0], r[5], z));
        jop = prog[mpc % 64];
        if (r[0]) mpc++;
        e = r[1] | (r[2] & z) | (r[3] & ~z);
        if (e) break;
        if (r[4] && !cb) begin
          mmop = jop;
          q.push_back(mk(3'd3, maddr, mmop, 1'b0, 1'b0, 1'b0, 1'($urandom % 2)));
          maddr = cblut[jop];
          cb = 1'b1;
        end else if (maddr == 8'd255) begin
          f = 1'b1;
          break;
        end else begin
          maddr = maddr + 8'd1;
        end
      end
    end
    while (f && q.size() < 300)
      q.push_back(mk(3'd5, 8'd255, mmop, 1'b1, 1'b0, 1'b0, 1'($urandom % 2)));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       ok, seen, done;
    int         t_first, n_exec, n_inc, n_fu, n_cb;
    logic [7:0] first_a, last_a;
    logic       st;
    item_t      it;

    rst_n = 1'b0; stall = 1'b0; zero = 1'b0; seti = 1'b0; ceti = 1'b0;
    int_flags = 5'd0; int_enable = 5'd0;
    clear_env();

    // Directed ROM contents
    rom[0]   = R_EOF;
    rom[162] = R_INC | R_EOF;
    rom[17]  = R_INC; rom[19] = R_EOFZ; rom[22] = R_EOF;
    rom[13]  = R_INC; rom[15] = R_JCB; rom[16] = R_FU | R_EOF | R_INC;
    rom[50]  = R_INC; rom[52] = R_EOF;
    rom[60]  = R_EOF; rom[169] = R_EOF;
    cblut[8'h7C] = 8'd16;
    prog[1] = 8'h7C;

    // ---- reset state ----
    @(negedge clk);
    chk("reset_async_state", {61'd0, state_out}, 64'd0);
    do_reset();
    chk("reset_state", {61'd0, state_out}, 64'd0);
    chk("reset_addr", {56'd0, uop_addr}, 64'd0);
    chk("reset_mop", {56'd0, mop_out}, 64'd0);
    chk("reset_flags", {59'd0, fault, pc_inc, flag_update, 2'b00}, 64'd0);
    chk("reset_int", {51'd0, int_ack, int_vector}, 64'd0);

    // ---- table-driven flows ----
    vecs[0] = '{8'h00, 8'd162, 1'b0, 8'd162, 8'd162, 1, 1, 0, 0, 8'h00};
    vecs[1] = '{8'h20, 8'd17,  1'b1, 8'd17,  8'd19,  3, 1, 0, 0, 8'h20};
    vecs[2] = '{8'h20, 8'd17,  1'b0, 8'd17,  8'd22,  6, 1, 0, 0, 8'h20};
    vecs[3] = '{8'hCB, 8'd13,  1'b0, 8'd13,  8'd16,  4, 2, 1, 1, 8'h7C};
    vecs[4] = '{8'hD3, 8'd0,   1'b0, 8'd0,   8'd0,   1, 0, 0, 0, 8'hD3};
    vecs[5] = '{8'h20, 8'd19,  1'b1, 8'd19,  8'd19,  1, 0, 0, 0, 8'h20};

    for (int v = 0; v < 6; v++) begin
      prog[0] = vecs[v].op;
      lut[vecs[v].op] = vecs[v].idx;
      zero = vecs[v].z;
      do_reset();
      seen = 1'b0; done = 1'b0; t_first = -1;
      n_exec = 0; n_inc = 0; n_fu = 0; n_cb = 0; first_a = 8'd0; last_a = 8'd0;
      for (int c = 0; c < 40; c++) begin
        if (state_out == 3'd2) begin
          if (!seen) begin first_a = uop_addr; t_first = c; end
          seen = 1'b1; n_exec++; last_a = uop_addr;
        end
        if (state_out == 3'd3) n_cb++;
        n_inc += int'(pc_inc);
        n_fu  += int'(flag_update);
        if (seen && state_out == 3'd0) begin done = 1'b1; break; end
        @(negedge clk);
      end
      $display("vec %0d op=%0h idx=%0d z=%0b exec=%0d last=%0d", v, vecs[v].op, vecs[v].idx,
               vecs[v].z, n_exec, last_a);
      chk("vec_done", {63'd0, done}, 64'd1);
      chk("vec_latency", 64'(t_first), 64'd2);
      chk("vec_first_addr", {56'd0, first_a}, {56'd0, vecs[v].first_addr});
      chk("vec_last_addr", {56'd0, last_a}, {56'd0, vecs[v].last_addr});
      chk("vec_exec_cycles", 64'(n_exec), 64'(vecs[v].exec_n));
      chk("vec_pc_inc", 64'(n_inc), 64'(vecs[v].inc_n));
      chk("vec_flag_update", 64'(n_fu), 64'(vecs[v].fu_n));
      chk("vec_cbdec", 64'(n_cb), 64'(vecs[v].cb_n));
      chk("vec_mop", {56'd0, mop_out}, {56'd0, vecs[v].last_mop});
    end
    zero = 1'b0;

    // ---- stall at addr 50 ----
    prog[0] = 8'h77; lut[8'h77] = 8'd50;
    do_reset();
    wait_exec(8'd50, ok);
    chk("stall_reach", {63'd0, ok}, 64'd1);
    for (int i = 0; i < 3; i++) begin
      stall = 1'b1;
      #1;
      $display("stall cycle %0d addr=%0d state=%0d", i, uop_addr, state_out);
      chk("stall_hold", {48'd0, 5'd0, state_out, uop_addr, pc_inc, flag_update, 6'd0},
          {48'd0, 5'd0, 3'd2, 8'd50, 1'b0, 1'b0, 6'd0});
      @(negedge clk);
    end
    stall = 1'b0;
    #1;
    chk("stall_release_inc", {55'd0, uop_addr, pc_inc}, {55'd0, 8'd50, 1'b1});
    @(negedge clk);
    chk("stall_resume_addr", {56'd0, uop_addr}, 64'd51);
    chk("stall_pc_once", {56'd0, pc}, 64'd1);

    // ---- overrun at top of ROM ----
    prog[0] = 8'h55; lut[8'h55] = 8'd254;
    do_reset();
    wait_exec(8'd254, ok);
    chk("ovr_reach", {63'd0, ok}, 64'd1);
    @(negedge clk);
    chk("ovr_top", {53'd0, state_out, uop_addr}, {53'd0, 3'd2, 8'd255});
    @(negedge clk);
    $display("overrun state=%0d addr=%0d fault=%0b", state_out, uop_addr, fault);
    chk("ovr_halt", {52'd0, fault, state_out, uop_addr}, {52'd0, 1'b1, 3'd5, 8'd255});
    repeat (4) @(negedge clk);
    chk("ovr_sticky", {52'd0, fault, state_out, uop_addr}, {52'd0, 1'b1, 3'd5, 8'd255});
    do_reset();
    chk("ovr_reset_clears", {63'd0, fault}, 64'd0);

    // ---- asynchronous reset mid-flow ----
    prog[0] = 8'h20; lut[8'h20] = 8'd17;
    do_reset();
    wait_exec(8'd17, ok);
    chk("abort_reach", {55'd0, uop_addr, pc_inc}, {55'd0, 8'd17, 1'b1});
    #2 rst_n = 1'b0;
    #1;
    $display("abort state=%0d addr=%0d pcinc=%0b", state_out, uop_addr, pc_inc);
    chk("abort_now", {44'd0, state_out, uop_addr, mop_out, pc_inc}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

`ifdef DZCPU_INT_DISPATCH_EN
    // ---- interrupt entry ----
    prog[0] = 8'h11; prog[1] = 8'h11; lut[8'h11] = 8'd60;
    int_enable = 5'h1F; int_flags = 5'h00; seti = 1'b1;
    do_reset();
    wait_exec(8'd60, ok);
    chk("int_ei_reach", {63'd0, ok}, 64'd1);
    @(negedge clk);
    seti = 1'b0;
    int_flags = 5'h05;
    ok = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (state_out == 3'd4) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    chk("int_enter", {63'd0, ok}, 64'd1);
    chk("int_ack", {59'd0, int_ack}, 64'd1);
    @(negedge clk);
    $display("int state=%0d addr=%0d vec=%0h", state_out, uop_addr, int_vector);
    chk("int_flow", {45'd0, state_out, uop_addr, int_vector}, {45'd0, 3'd2, 8'd169, 8'h40});
    @(negedge clk);
    chk("int_ime_cleared", {61'd0, state_out}, 64'd0);
    int_flags = 5'h00; int_enable = 5'h00;
`endif

    // ---- randomized runs against the trace model ----
    for (int run = 0; run < 3; run++) begin
      for (int a = 0; a < 256; a++) begin
        int u;
        rom[a] = 6'd0;
        if ($urandom % 2 == 0) rom[a] |= R_INC;
        u = int'($urandom % 12);
        if (u < 3)      rom[a] |= R_EOF;
        else if (u < 5) rom[a] |= R_EOFZ;
        else if (u < 7) rom[a] |= R_EOFNZ;
        if ($urandom % 8 == 0) rom[a] |= R_JCB;
        if ($urandom % 3 == 0) rom[a] |= R_FU;
        lut[a]   = 8'($urandom);
        cblut[a] = 8'($urandom);
      end
      for (int i = 0; i < 64; i++) prog[i] = 8'($urandom);
      build_trace();
      do_reset();
      for (int k = 0; k < q.size(); ) begin
        it = q[k];
        st = ($urandom % 6 == 0);
        stall = st;
        zero = it.z;
        #1;
        chk($sformatf("trace run%0d item%0d", run, k),
            {25'd0, state_out, uop_addr, mop_out, fault, pc_inc, flag_update, int_ack, int_vector},
            {25'd0, it.st, it.addr, it.mop, it.flt, it.inc & ~st, it.fu & ~st, 5'd0, 8'd0});
        if (!st) k++;
        @(negedge clk);
      end
      stall = 1'b0;
      $display("random run %0d items=%0d errors=%0d", run, q.size(), errors);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
